simd_issue_ctrl: RTL and testbench



---
 rtl/simd_pkg.sv | 47 ++++
 rtl/simd_instr_decode.sv | 33 +++
 rtl/simd_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_simd_issue_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: shared definitions for the SIMD issue controller slice.
//   - datapath/address width defaults
//   - instruction word field positions
//   - opcode values and ALU enable vector bit positions
//   - issue FSM state encoding
package simd_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int INSTR_W    = 36;

  // Instruction word layout; bit 16 is reserved and ignored.
  localparam int OP_HI  = 35;
  localparam int OP_LO  = 32;
  localparam int RD_HI  = 31;
  localparam int RD_LO  = 27;
  localparam int RS1_HI = 26;
  localparam int RS1_LO = 22;
  localparam int RS2_HI = 21;
  localparam int RS2_LO = 17;
  localparam int RSV_B  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Opcodes 6..15 are undefined, so these stay plain constants rather than an enum.
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_BREV = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;

  // Bit positions inside the one-hot ALU enable vector.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_BREV = 2;
  localparam int ALU_MUL  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WB,
    S_RESP
  } state_e;

endpackage

// File: rtl/simd_instr_decode.sv
// simd_instr_decode: combinational opcode decoder.
//   op_i        : 4-bit opcode
//   alu_en_o    : one-hot ALU enable {mul, brev, sub, add}; zero for non-ALU ops
//   is_ldi_o    : load-immediate
//   is_nop_o    : no-operation
//   is_illegal_o: opcode 6..15
module simd_instr_decode
  import simd_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [3:0] alu_en_o,
  output logic       is_ldi_o,
  output logic       is_nop_o,
  output logic       is_illegal_o
);

  always_comb begin
    alu_en_o     = '0;
    is_ldi_o     = 1'b0;
    is_nop_o     = 1'b0;
    is_illegal_o = 1'b0;
    case (op_i)
      OP_NOP:  is_nop_o = 1'b1;
      OP_LDI:  is_ldi_o = 1'b1;
      OP_ADD:  alu_en_o[ALU_ADD]  = 1'b1;
      OP_SUB:  alu_en_o[ALU_SUB]  = 1'b1;
      OP_BREV: alu_en_o[ALU_BREV] = 1'b1;
      OP_MUL:  alu_en_o[ALU_MUL]  = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/simd_issue_ctrl.sv
// simd_issue_ctrl: sequences one instruction at a time into a SIMD lane.
//   clk, rst          : clock, synchronous active-low reset
//   instr_*           : instruction valid/ready handshake + 36-bit word
//   rs1, rs2, rd      : lane register addresses (held dispatch..writeback)
//   wr_data, rd_wr_en : lane register writeback
//   rs1_rd_en, rs2_rd_en, Radd_en, Rsub_en, bitrev_en, mul_en : lane read/ALU enables
//   aluresult_in      : lane ALU result, captured at end of the read phase
//   res_*             : result valid/ready handshake
//   illegal_op        : one-cycle pulse after an undefined opcode is accepted
module simd_issue_ctrl
  import simd_pkg::*;
#(
  parameter int RF_RD_LAT = 1,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  rs1,
  output logic [ADDR_W-1:0]  rs2,
  output logic [ADDR_W-1:0]  rd,
  output logic [DATA_W-1:0]  wr_data,
  output logic               rd_wr_en,
  output logic               rs1_rd_en,
  output logic               rs2_rd_en,
  output logic               Radd_en,
  output logic               Rsub_en,
  output logic               bitrev_en,
  output logic               mul_en,
  input  logic [DATA_W-1:0]  aluresult_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               illegal_op
);

  localparam int CNT_W = 3;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]  imm_q, res_q;
  logic [3:0]         alu_en_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               illegal_q;

  logic [3:0]         dec_alu_en;
  logic               dec_ldi, dec_nop, dec_illegal;
  logic               accept;
  logic               unused_rsv;

  assign unused_rsv = instr_data[RSV_B];

  simd_instr_decode u_decode (
    .op_i         (instr_data[OP_HI:OP_LO]),
    .alu_en_o     (dec_alu_en),
    .is_ldi_o     (dec_ldi),
    .is_nop_o     (dec_nop),
    .is_illegal_o (dec_illegal)
  );

  // instr_ready is qualified by rst so every output reads 0 while reset is held.
  assign accept     = instr_valid && (state_q == S_IDLE) && rst;
  assign illegal_op = illegal_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      alu_en_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept && dec_illegal;
      if (accept) begin
        rd_q     <= ADDR_W'(instr_data[RD_HI:RD_LO]);
        rs1_q    <= ADDR_W'(instr_data[RS1_HI:RS1_LO]);
        rs2_q    <= ADDR_W'(instr_data[RS2_HI:RS2_LO]);
        imm_q    <= DATA_W'(instr_data[IMM_HI:IMM_LO]);
        alu_en_q <= dec_alu_en;
      end
      // Down-counter is preloaded outside READ, so READ lasts RF_RD_LAT+1 cycles.
      if (state_q == S_READ) cnt_q <= cnt_q - 1'b1;
      else                   cnt_q <= CNT_W'(RF_RD_LAT);
      if (state_q == S_WRITE)
        res_q <= imm_q;
      else if (state_q == S_READ && cnt_q == '0)
        res_q <= aluresult_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rs1         = '0;
    rs2         = '0;
    rd          = '0;
    wr_data     = '0;
    rd_wr_en    = 1'b0;
    rs1_rd_en   = 1'b0;
    rs2_rd_en   = 1'b0;
    Radd_en     = 1'b0;
    Rsub_en     = 1'b0;
    bitrev_en   = 1'b0;
    mul_en      = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    case (state_q)
      S_IDLE: begin
        instr_ready = rst;
        if (accept) begin
          if (dec_ldi)                       state_d = S_WRITE;
          else if (!dec_nop && !dec_illegal) state_d = S_READ;
        end
      end
      S_WRITE: begin
        rs1      = rs1_q;
        rs2      = rs2_q;
        rd       = rd_q;
        wr_data  = imm_q;
        rd_wr_en = 1'b1;
        state_d  = S_RESP;
      end
      S_READ: begin
        rs1       = rs1_q;
        rs2       = rs2_q;
        rd        = rd_q;
        rs1_rd_en = 1'b1;
        rs2_rd_en = 1'b1;
        Radd_en   = alu_en_q[ALU_ADD];
        Rsub_en   = alu_en_q[ALU_SUB];
        bitrev_en = alu_en_q[ALU_BREV];
        mul_en    = alu_en_q[ALU_MUL];
        if (cnt_q == '0) state_d = S_WB;
      end
      S_WB: begin
        rs1      = rs1_q;
        rs2      = rs2_q;
        rd       = rd_q;
        wr_data  = res_q;
        rd_wr_en = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        res_valid = 1'b1;
        res_data  = res_q;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// tb_simd_issue_ctrl: randomized self-checking bench for simd_issue_ctrl.
// Each instruction is checked at transaction level: expected enable cycle
// counts, writeback address/value, response latency and value are derived
// from the opcode and the read latency LAT.
module tb_simd_issue_ctrl;
  parameter int LAT = 1;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [35:0] instr_data;
  logic [4:0]  rs1, rs2, rd;
  logic [15:0] wr_data;
  logic        rd_wr_en, rs1_rd_en, rs2_rd_en;
  logic        Radd_en, Rsub_en, bitrev_en, mul_en;
  logic [15:0] aluresult_in;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  simd_issue_ctrl #(.RF_RD_LAT(LAT), .DATA_W(16), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wr_data(wr_data), .rd_wr_en(rd_wr_en),
    .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
    .Radd_en(Radd_en), .Rsub_en(Rsub_en), .bitrev_en(bitrev_en), .mul_en(mul_en),
    .aluresult_in(aluresult_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {9'd0, rs1, rs2, rd, wr_data, rd_wr_en, rs1_rd_en, rs2_rd_en,
            Radd_en, Rsub_en, bitrev_en, mul_en, res_valid, res_data, illegal_op};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_instr(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [15:0] imm, input int hold);
    logic [15:0] vals [0:15];
    logic [15:0] exp_res;
    logic [3:0]  exp_en, en;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_val  = '0;
    bit is_alu, is_ldi, active, done;
    int exp_lat, limit;
    int n_rd = 0, n_bad_rd = 0, n_en_ok = 0, n_en_bad = 0, n_wr = 0, n_ill = 0;
    int ill_c = -1, n_res_bad = 0, first_v = -1, resp_cyc = 0, n_rdy = 0, n_notrdy = 0;

    for (int i = 0; i < 16; i++) vals[i] = 16'($urandom);
    is_alu  = (op >= 4'd2 && op <= 4'd5);
    is_ldi  = (op == 4'd1);
    active  = is_alu || is_ldi;
    exp_en  = is_alu ? 4'(1 << (op - 4'd2)) : 4'b0;
    exp_res = is_ldi ? imm : vals[LAT + 1];
    exp_lat = is_ldi ? 2 : LAT + 3;
    limit   = active ? 60 : 3;
    done    = 0;

    check_val("ready_before_issue", instr_ready, 1);
    instr_valid  = 1'b1;
    instr_data   = {op, d, s1, s2, 1'($urandom), imm};
    aluresult_in = vals[0];
    res_ready    = 1'($urandom);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_data  = 36'({$urandom, $urandom});

    for (int c = 1; c <= limit && !done; c++) begin
      en = {mul_en, bitrev_en, Rsub_en, Radd_en};
      if (rd_wr_en) begin n_wr++; wr_addr = rd; wr_val = wr_data; end
      if (rs1_rd_en || rs2_rd_en) begin
        n_rd++;
        if (!(rs1_rd_en && rs2_rd_en) || rs1 !== s1 || rs2 !== s2 || rd !== d) n_bad_rd++;
      end
      if (en != 4'b0 && en == exp_en) n_en_ok++;
      else if (en != 4'b0) n_en_bad++;
      if (illegal_op) begin n_ill++; if (ill_c < 0) ill_c = c; end
      if (instr_ready) n_rdy++; else n_notrdy++;
      if (res_valid) begin
        if (first_v < 0) first_v = c;
        if (res_data !== exp_res) n_res_bad++;
        res_ready = (resp_cyc >= hold);
        if (res_ready) done = 1;
        resp_cyc++;
      end else begin
        res_ready = 1'($urandom);
      end
      aluresult_in = vals[(c < 15) ? c : 15];
      @(negedge clk);
    end

    if (active) begin
      check_val("completed", done, 1);
      check_val("wr_count", n_wr, 1);
      check_val("wr_addr", wr_addr, d);
      check_val("wr_data", wr_val, exp_res);
      check_val("rd_en_cycles", n_rd, is_alu ? LAT + 1 : 0);
      check_val("rd_addr_bad", n_bad_rd, 0);
      check_val("op_en_cycles", n_en_ok, is_alu ? LAT + 1 : 0);
      check_val("op_en_wrong", n_en_bad, 0);
      check_val("latency", first_v, exp_lat);
      check_val("res_data_bad", n_res_bad, 0);
      check_val("resp_cycles", resp_cyc, hold + 1);
      check_val("ready_while_busy", n_rdy, 0);
      check_val("illegal_on_legal", n_ill, 0);
      check_val("after_resp_ready", instr_ready, 1);
      check_val("after_resp_quiet", all_outs(), 0);
    end else begin
      check_val("nop_ill_wr", n_wr, 0);
      check_val("nop_ill_rd", n_rd, 0);
      check_val("nop_ill_en", n_en_bad + n_en_ok, 0);
      check_val("nop_ill_resp", first_v, -1);
      check_val("nop_ill_ready", n_notrdy, 0);
      check_val("illegal_count", n_ill, (op == 4'd0) ? 0 : 1);
      check_val("illegal_cycle", ill_c, (op == 4'd0) ? -1 : 1);
    end
  endtask

  task automatic reset_mid_sub();
    int n_wr = 0, n_v = 0, n_nr = 0;
    check_val("ready_before_sub", instr_ready, 1);
    instr_valid  = 1'b1;
    instr_data   = {4'd3, 5'd7, 5'd1, 5'd2, 1'b0, 16'h0};
    aluresult_in = 16'($urandom);
    res_ready    = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check_val("sub_in_read", {rs1_rd_en, Rsub_en}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_mid_quiet", all_outs(), 0);
    check_val("rst_mid_ready", instr_ready, 0);
    rst = 1'b1;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (rd_wr_en) n_wr++;
      if (res_valid) n_v++;
      if (!instr_ready) n_nr++;
    end
    check_val("rst_no_wb", n_wr, 0);
    check_val("rst_no_resp", n_v, 0);
    check_val("rst_ready_after", n_nr, 0);
  endtask

  initial begin
    rst          = 1'b0;
    instr_valid  = 1'b0;
    instr_data   = '0;
    aluresult_in = '0;
    res_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", all_outs(), 0);
    check_val("reset_ready", instr_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_reset_ready", instr_ready, 1);
    check_val("post_reset_outs", all_outs(), 0);

    run_instr(4'd1, 5'd3, 5'd0, 5'd0, 16'h1234, 0);   // LDI
    run_instr(4'd2, 5'd5, 5'd3, 5'd4, 16'h0, 1);      // ADD
    run_instr(4'd5, 5'd1, 5'd2, 5'd6, 16'h0, 10);     // MUL with back-pressure
    run_instr(4'd9, 5'd4, 5'd4, 5'd4, 16'hFFFF, 0);   // illegal
    run_instr(4'd0, 5'd8, 5'd9, 5'd10, 16'hBEEF, 0);  // NOP
    run_instr(4'd3, 5'd0, 5'd0, 5'd0, 16'h0, 0);      // SUB, rd=rs=0
    run_instr(4'd4, 5'd31, 5'd30, 5'd29, 16'h0, 2);   // BREV
    run_instr(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 0);     // illegal boundary
    run_instr(4'd6, 5'd0, 5'd0, 5'd0, 16'h0, 0);      // illegal boundary
    reset_mid_sub();
    run_instr(4'd1, 5'd12, 5'd0, 5'd0, 16'h00A5, 0);  // LDI after mid-op reset

    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      run_instr(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
